// File: rtl/cfu_mac_seq.sv
// rtl/cfu_mac_seq.sv - command sequencer driving the CFU offset/accumulator register block
// Optional build macro: CFU_MAC_SEQ_SKIP_ZERO_EN (MAC4 visits only lanes with a nonzero filter byte)
module cfu_mac_seq #(
    parameter bit IN_SIGNED  = 1'b1,
    parameter bit FLT_SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_funct3,
    input  logic [31:0] cmd_in0,
    input  logic [31:0] cmd_in1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        flag_write_offset,
    output logic        flag_add_acc,
    output logic        flag_clear_acc,
    output logic [31:0] reg_value,
    input  logic [31:0] offset,
    input  logic [31:0] acc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        MAC  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] F_WR_OFFSET = 3'd0;
    localparam logic [2:0] F_CLR_ACC   = 3'd1;
    localparam logic [2:0] F_MAC4      = 3'd2;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  op_q;
    logic [31:0] in0_q;
    logic [31:0] in1_q;
    logic        accept;
    logic [1:0]  lane;
    logic        last_lane;
    logic        mac_skip_all;

    logic [7:0]  in_byte;
    logic [7:0]  flt_byte;
    logic [31:0] in_ext;
    logic [31:0] flt_ext;
    logic [31:0] lane_sum;
    logic [31:0] lane_term;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef CFU_MAC_SEQ_SKIP_ZERO_EN
    logic [3:0] todo_q;
    logic [3:0] todo_left;
    logic [3:0] cmd_nz;

    assign cmd_nz = {|cmd_in1[31:24], |cmd_in1[23:16], |cmd_in1[15:8], |cmd_in1[7:0]};

    // Priority encoder: lowest lane still waiting to be accumulated
    always_comb begin
        lane = 2'd0;
        if (todo_q[0])      lane = 2'd0;
        else if (todo_q[1]) lane = 2'd1;
        else if (todo_q[2]) lane = 2'd2;
        else if (todo_q[3]) lane = 2'd3;
    end

    assign todo_left    = todo_q & ~(4'b0001 << lane);
    assign last_lane    = (todo_left == 4'b0000);
    assign mac_skip_all = (cmd_nz == 4'b0000);

    // Remaining-lane mask: loaded on accept, one lane retired per MAC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            todo_q <= 4'b0000;
        end else if (accept) begin
            todo_q <= cmd_nz;
        end else if (state == MAC) begin
            todo_q <= todo_left;
        end
    end
`else
    logic [1:0] lane_q;

    assign lane         = lane_q;
    assign last_lane    = (lane_q == 2'd3);
    assign mac_skip_all = 1'b0;

    // Lane counter: restarts at 0 on accept, steps once per MAC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= 2'd0;
        end else if (accept) begin
            lane_q <= 2'd0;
        end else if (state == MAC) begin
            lane_q <= lane_q + 2'd1;
        end
    end
`endif

    // Operand latches captured on the accepting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= 3'd0;
            in0_q <= 32'd0;
            in1_q <= 32'd0;
        end else if (accept) begin
            op_q  <= cmd_funct3;
            in0_q <= cmd_in0;
            in1_q <= cmd_in1;
        end
    end

    // Per-lane term; the offset is taken live from the register block
    assign in_byte   = in0_q[{lane, 3'b000} +: 8];
    assign flt_byte  = in1_q[{lane, 3'b000} +: 8];
    assign in_ext    = {{24{IN_SIGNED & in_byte[7]}}, in_byte};
    assign flt_ext   = {{24{FLT_SIGNED & flt_byte[7]}}, flt_byte};
    assign lane_sum  = in_ext + offset;
    assign lane_term = lane_sum * flt_ext;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and decoded strobes; reset silences every strobe so an abandoned MAC adds nothing more
    always_comb begin
        state_nxt         = state;
        flag_write_offset = 1'b0;
        flag_clear_acc    = 1'b0;
        flag_add_acc      = 1'b0;
        reg_value         = 32'd0;
        rsp_valid         = 1'b0;
        rsp_data          = 32'd0;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_funct3)
                        F_WR_OFFSET, F_CLR_ACC: state_nxt = OP;
                        F_MAC4:                 state_nxt = mac_skip_all ? RESP : MAC;
                        default:                state_nxt = RESP;
                    endcase
                end
            end
            OP: begin
                state_nxt = RESP;
                if (!reset) begin
                    if (op_q == F_WR_OFFSET) begin
                        flag_write_offset = 1'b1;
                        reg_value         = in0_q;
                    end else if (op_q == F_CLR_ACC) begin
                        flag_clear_acc = 1'b1;
                    end
                end
            end
            MAC: begin
                if (last_lane) begin
                    state_nxt = RESP;
                end
                if (!reset) begin
                    flag_add_acc = 1'b1;
                    reg_value    = lane_term;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
                if (!reset) begin
                    rsp_valid = 1'b1;
                    rsp_data  = (op_q == F_WR_OFFSET) ? offset : acc;
                end
            end
        endcase
    end

endmodule
